circle_sprites: RTL

Parametrised multi-circle sprite generator for the VGA pixel path. Renders up to N_SPR filled circles, each with its own centre, radius, colour and enable. Sprite attributes are written through a valid/ready configuration port into shadow registers and take effect atomically at frame start, so there is no tearing. A 3-stage pipeline produces one RGBA pixel per clock, plus a per-frame sprite-overlap (collision) report for game logic.

---
 rtl/circle_sprites_pkg.sv | 32 +++
 rtl/circle_sprites_hit.sv | 54 +++++
 rtl/circle_sprites.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/circle_sprites_pkg.sv
// ============================================================================
// Module   : circle_sprites_pkg
// Purpose  : Shared types and helpers for the circle sprite generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package circle_sprites_pkg;

    typedef logic [31:0] rgba_t;

    localparam rgba_t RGBA_BG = 32'h000000FF;

    // Storage widths are fixed; the top keeps only its low COORD_W / R_W bits live.
    localparam int CFG_XY_W = 16;
    localparam int CFG_R_W  = 16;

    typedef struct packed {
        logic [CFG_XY_W-1:0] x;
        logic [CFG_XY_W-1:0] y;
        logic [CFG_R_W-1:0]  r;
        logic [23:0]         color;
        logic                en;
    } spr_cfg_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/circle_sprites_hit.sv
// ============================================================================
// Module   : circle_hit
// Purpose  : Per-sprite stages 1-2: registered offsets, then registered dist^2 and r^2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module circle_hit #(
    parameter  int COORD_W = 11,
    parameter  int R_W     = 7,
    localparam int D_W     = 2*COORD_W + 3,
    localparam int R2_W    = 2*R_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [COORD_W-1:0] spotX,
    input  logic signed [COORD_W-1:0] spotY,
    input  logic signed [COORD_W-1:0] cx,
    input  logic signed [COORD_W-1:0] cy,
    input  logic        [R_W-1:0]     r,
    input  logic                      en,
    output logic        [D_W-1:0]     dist2,
    output logic        [R2_W-1:0]    r2
);

    logic signed [COORD_W:0] w_dx, w_dy, r_dx, r_dy;
    logic        [R2_W-1:0]  r_r2_s1;
    logic signed [D_W-1:0]   w_dxe, w_dye;

    assign w_dx  = {spotX[COORD_W-1], spotX} - {cx[COORD_W-1], cx};
    assign w_dy  = {spotY[COORD_W-1], spotY} - {cy[COORD_W-1], cy};
    assign w_dxe = D_W'(r_dx);
    assign w_dye = D_W'(r_dy);

    // A disabled sprite gets r^2 = 0, which no distance can undercut.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dx    <= '0;
            r_dy    <= '0;
            r_r2_s1 <= '0;
            dist2   <= '0;
            r2      <= '0;
        end else begin
            r_dx    <= w_dx;
            r_dy    <= w_dy;
            r_r2_s1 <= en ? R2_W'(r) * R2_W'(r) : '0;
            dist2   <= $unsigned(w_dxe * w_dxe + w_dye * w_dye);
            r2      <= r_r2_s1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/circle_sprites.sv
// ============================================================================
// Module   : circle_sprites
// Purpose  : N filled-circle sprite renderer with shadow/active banks and collision report.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module circle_sprites
    import circle_sprites_pkg::*;
#(
    parameter  int N_SPR   = 4,
    parameter  int COORD_W = 11,
    parameter  int R_W     = 7,
    localparam int IDX_W   = idx_w(N_SPR)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [COORD_W-1:0] spotX,
    input  logic signed [COORD_W-1:0] spotY,
    input  logic                      frame_start,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic        [IDX_W-1:0]   cfg_idx,
    input  logic signed [COORD_W-1:0] cfg_x,
    input  logic signed [COORD_W-1:0] cfg_y,
    input  logic        [R_W-1:0]     cfg_r,
    input  logic        [23:0]        cfg_color,
    input  logic                      cfg_en,
    output logic        [31:0]        spr_rgba,
    output logic                      spr_hit,
    output logic        [IDX_W-1:0]   spr_idx,
    output logic                      collision,
    output logic        [N_SPR-1:0]   collision_mask
);

    localparam int D_W  = 2*COORD_W + 3;
    localparam int R2_W = 2*R_W;

    spr_cfg_t          r_shd [N_SPR];
    spr_cfg_t          r_act [N_SPR];
    spr_cfg_t          w_wr;
    logic              w_wr_en;
    logic [D_W-1:0]    w_dist2 [N_SPR];
    logic [R2_W-1:0]   w_r2 [N_SPR];
    logic [23:0]       r_col1 [N_SPR];
    logic [23:0]       r_col2 [N_SPR];
    logic [1:0]        r_v;
    logic [N_SPR-1:0]  w_hits;
    logic [IDX_W-1:0]  w_win_idx;
    logic [23:0]       w_win_col;
    logic              w_multi;
    logic              r_acc;
    logic [N_SPR-1:0]  r_acc_mask;
    logic [N_SPR-1:0]  w_unused_bits;

    assign cfg_ready = !reset && !frame_start;
    assign w_wr_en   = cfg_valid && cfg_ready && (32'(cfg_idx) < 32'(N_SPR));

    always_comb begin
        w_wr       = '0;
        w_wr.x     = CFG_XY_W'(cfg_x);
        w_wr.y     = CFG_XY_W'(cfg_y);
        w_wr.r     = CFG_R_W'(cfg_r);
        w_wr.color = cfg_color;
        w_wr.en    = cfg_en;
    end

    // Shadow writes never coincide with the copy because cfg_ready drops on frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SPR; i++) begin
                r_shd[i] <= '0;
                r_act[i] <= '0;
            end
        end else begin
            if (w_wr_en)
                r_shd[cfg_idx] <= w_wr;
            if (frame_start)
                r_act <= r_shd;
        end
    end

    generate
        for (genvar g = 0; g < N_SPR; g++) begin : g_spr
            circle_hit #(
                .COORD_W (COORD_W),
                .R_W     (R_W)
            ) u_hit (
                .clk   (clk),
                .reset (reset),
                .spotX (spotX),
                .spotY (spotY),
                .cx    (r_act[g].x[COORD_W-1:0]),
                .cy    (r_act[g].y[COORD_W-1:0]),
                .r     (r_act[g].r[R_W-1:0]),
                .en    (r_act[g].en),
                .dist2 (w_dist2[g]),
                .r2    (w_r2[g])
            );
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < N_SPR; i++)
            w_unused_bits[i] = ^r_act[i];
    end

    // Colour travels alongside the hit pipeline so a mid-pipe bank swap cannot tear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SPR; i++) begin
            r_col1[i] <= r_act[i].color;
            r_col2[i] <= r_col1[i];
        end
    end

    always_comb begin
        w_hits    = '0;
        w_win_idx = '0;
        w_win_col = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            w_hits[i] = r_v[1] && (w_dist2[i] < D_W'(w_r2[i]));
            if (w_hits[i]) begin
                w_win_idx = IDX_W'(i);
                w_win_col = r_col2[i];
            end
        end
    end

    assign w_multi = |(w_hits & (w_hits - N_SPR'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v            <= '0;
            spr_rgba       <= RGBA_BG;
            spr_hit        <= 1'b0;
            spr_idx        <= '0;
            collision      <= 1'b0;
            collision_mask <= '0;
            r_acc          <= 1'b0;
            r_acc_mask     <= '0;
        end else begin
            r_v <= {r_v[0], 1'b1};
            if (r_v[1]) begin
                spr_hit  <= |w_hits;
                spr_idx  <= w_win_idx;
                spr_rgba <= (|w_hits) ? {w_win_col, 8'h00} : RGBA_BG;
            end
            if (frame_start) begin
                collision      <= r_acc | w_multi;
                collision_mask <= r_acc_mask | (w_multi ? w_hits : '0);
                r_acc          <= 1'b0;
                r_acc_mask     <= '0;
            end else if (w_multi) begin
                r_acc      <= 1'b1;
                r_acc_mask <= r_acc_mask | w_hits;
            end
        end
    end

endmodule

`default_nettype wire
